// File: rtl/int_seq_if.sv
// Bundle of the sequencer's decoder/PC-side inputs and register-file-side outputs.
// The slave modport belongs to int_sequencer; the master modport belongs to whatever drives it.
interface int_seq_if;
  // Every control is a level or a one-clk strobe sampled on the rising clk edge.
  // There is no valid/ready back-pressure: a strobe is seen exactly once.
  logic        irq;
  logic        ibound;
  logic [15:0] pc;
  logic        ei;
  logic        di;
  logic        rti;
  logic        ienabled;
  logic        istatus;
  logic [15:0] intRA;
  logic        vec_load;
  logic [15:0] vec_addr;
  logic        ret_load;
  logic        pending;

  modport slave (
    input  irq, ibound, pc, ei, di, rti,
    output ienabled, istatus, intRA, vec_load, vec_addr, ret_load, pending
  );

  modport master (
    output irq, ibound, pc, ei, di, rti,
    input  ienabled, istatus, intRA, vec_load, vec_addr, ret_load, pending
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt sequencer: synchronises irq, latches it as pending, and walks the
// IDLE -> TAKE -> ACTIVE -> RETURN sequence that drives the register file's interrupt controls.
module int_sequencer #(
    parameter logic [15:0] VECTOR      = 16'hFF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          nclr,
    int_seq_if.slave      bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TAKE   = 2'd1,
        S_ACTIVE = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   pending_q, pending_d;
    logic                   ienabled_q, ienabled_d;
    logic [15:0]            intra_q, intra_d;
    logic                   irq_edge;
    logic                   take_go;

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            pending_q  <= 1'b0;
            ienabled_q <= 1'b0;
            intra_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            pending_q  <= pending_d;
            ienabled_q <= ienabled_d;
            intra_q    <= intra_d;
        end
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.irq};
        hist_d   = sync_q[SYNC_STAGES-1];
        irq_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

        // di also vetoes the take so a disable in the boundary cycle always wins.
        take_go = (state_q == S_IDLE) & bus.ibound & pending_q & ienabled_q & ~bus.di;

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (take_go) state_d = S_TAKE;
            S_TAKE:   state_d = S_ACTIVE;
            S_ACTIVE: if (bus.rti) state_d = S_RETURN;
            S_RETURN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // A new edge arriving on the take edge keeps the request alive.
        pending_d = pending_q;
        if (irq_edge)     pending_d = 1'b1;
        else if (take_go) pending_d = 1'b0;

        ienabled_d = ienabled_q;
        if (bus.di)      ienabled_d = 1'b0;
        else if (bus.ei) ienabled_d = 1'b1;

        intra_d = intra_q;
        if ((state_q == S_IDLE) && bus.ibound) intra_d = bus.pc;
    end

    assign bus.ienabled = ienabled_q;
    assign bus.istatus  = (state_q == S_ACTIVE) || (state_q == S_RETURN);
    assign bus.intRA    = intra_q;
    assign bus.vec_load = (state_q == S_TAKE);
    assign bus.vec_addr = VECTOR;
    assign bus.ret_load = (state_q == S_RETURN);
    assign bus.pending  = pending_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios against fixed expectations,
// then random traffic against a behavioural model of the interrupt rules.
module tb_int_sequencer;
  localparam int SYNC = 2;

  logic       clk;
  logic       nclr;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;

  int_seq_if bus ();

  int_sequencer #(.VECTOR(16'hFF00), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .nclr      (nclr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // irq history: m_s[k] is irq as seen k+1 edges ago; the synchronised rise is
  // "SYNC edges ago high, SYNC+1 edges ago low".
  bit          m_s[$];
  int          m_mode;   // 0 idle, 1 taking, 2 in handler, 3 returning
  bit          m_pend;
  bit          m_ien;
  logic [15:0] m_ra;

  always @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      m_s.delete();
      for (int i = 0; i <= SYNC; i++) m_s.push_back(1'b0);
      m_mode = 0; m_pend = 0; m_ien = 0; m_ra = 16'h0000;
    end else begin
      bit rise, take;
      rise = m_s[SYNC-1] && !m_s[SYNC];
      take = (m_mode == 0) && bus.ibound && m_pend && m_ien && !bus.di;
      m_s.push_front(bus.irq);
      void'(m_s.pop_back());
      if (m_mode == 0 && bus.ibound) m_ra = bus.pc;
      m_pend = rise ? 1'b1 : (take ? 1'b0 : m_pend);
      m_ien  = bus.di ? 1'b0 : (bus.ei ? 1'b1 : m_ien);
      case (m_mode)
        0: m_mode = take ? 1 : 0;
        1: m_mode = 2;
        2: m_mode = bus.rti ? 3 : 2;
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit ib, input logic [15:0] p, input bit e, input bit d, input bit r);
    @(negedge clk);
    bus.ibound = ib; bus.pc = p; bus.ei = e; bus.di = d; bus.rti = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.irq = 0; bus.ibound = 0; bus.pc = 0; bus.ei = 0; bus.di = 0; bus.rti = 0;
    nclr = 1'b0;
    #12;
    n_cmp++; if (bus.ienabled !== 1'b0) begin n_err++; $display("FAIL reset_ienabled got=%b exp=0", bus.ienabled); end
    n_cmp++; if (bus.istatus !== 1'b0) begin n_err++; $display("FAIL reset_istatus got=%b exp=0", bus.istatus); end
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
    n_cmp++; if (bus.vec_load !== 1'b0 || bus.ret_load !== 1'b0) begin n_err++; $display("FAIL reset_strobes got=%b%b exp=00", bus.vec_load, bus.ret_load); end
    n_cmp++; if (bus.intRA !== 16'h0000) begin n_err++; $display("FAIL reset_intRA got=%h exp=0000", bus.intRA); end
    n_cmp++; if (bus.vec_addr !== 16'hFF00) begin n_err++; $display("FAIL reset_vec_addr got=%h exp=ff00", bus.vec_addr); end
    @(negedge clk);
    nclr = 1'b1;
  endtask

  task automatic test_take();
    idle(3);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    bus.irq = 1'b1;
    for (int i = 1; i <= SYNC; i++) begin
      idle(1);
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL take_pending_early clk=%0d got=%b exp=0", i, bus.pending); end
    end
    idle(1);
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL take_pending_latency got=%b exp=1", bus.pending); end
    cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.intRA !== 16'h1234) begin n_err++; $display("FAIL take_intRA got=%h exp=1234", bus.intRA); end
    n_cmp++; if (bus.vec_load !== 1'b1) begin n_err++; $display("FAIL take_vec_load got=%b exp=1", bus.vec_load); end
    n_cmp++; if (bus.vec_addr !== 16'hFF00) begin n_err++; $display("FAIL take_vec_addr got=%h exp=ff00", bus.vec_addr); end
    n_cmp++; if (bus.istatus !== 1'b0) begin n_err++; $display("FAIL take_istatus got=%b exp=0", bus.istatus); end
    idle(1);
    n_cmp++; if (bus.istatus !== 1'b1) begin n_err++; $display("FAIL active_istatus got=%b exp=1", bus.istatus); end
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL active_pending got=%b exp=0", bus.pending); end
    n_cmp++; if (bus.vec_load !== 1'b0) begin n_err++; $display("FAIL active_vec_load got=%b exp=0", bus.vec_load); end
  endtask

  task automatic test_return();
    idle(2);
    n_cmp++; if (bus.istatus !== 1'b1 || bus.intRA !== 16'h1234) begin n_err++; $display("FAIL hold_active got istatus=%b intRA=%h exp 1/1234", bus.istatus, bus.intRA); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.ret_load !== 1'b1) begin n_err++; $display("FAIL ret_load got=%b exp=1", bus.ret_load); end
    n_cmp++; if (bus.istatus !== 1'b1) begin n_err++; $display("FAIL ret_istatus got=%b exp=1", bus.istatus); end
    n_cmp++; if (bus.intRA !== 16'h1234) begin n_err++; $display("FAIL ret_intRA got=%h exp=1234", bus.intRA); end
    idle(1);
    n_cmp++; if (bus.ret_load !== 1'b0 || bus.istatus !== 1'b0) begin n_err++; $display("FAIL post_ret got ret_load=%b istatus=%b exp 0/0", bus.ret_load, bus.istatus); end
    n_cmp++; if (bus.intRA !== 16'h1234) begin n_err++; $display("FAIL post_ret_intRA got=%h exp=1234", bus.intRA); end
  endtask

  task automatic test_disabled();
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.ienabled !== 1'b0) begin n_err++; $display("FAIL dis_ienabled got=%b exp=0", bus.ienabled); end
    bus.irq = 1'b0; idle(4);
    bus.irq = 1'b1; idle(4);
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL dis_pending got=%b exp=1", bus.pending); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.vec_load !== 1'b0 || bus.pending !== 1'b1) begin n_err++; $display("FAIL dis_no_take i=%0d got vec_load=%b pending=%b exp 0/1", i, bus.vec_load, bus.pending); end
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.vec_load !== 1'b1 || bus.intRA !== 16'hABCD) begin n_err++; $display("FAIL en_take got vec_load=%b intRA=%h exp 1/abcd", bus.vec_load, bus.intRA); end
    idle(1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    n_cmp++; if (bus.istatus !== 1'b0) begin n_err++; $display("FAIL en_back_idle got=%b exp=0", bus.istatus); end
  endtask

  task automatic test_di_same();
    bus.irq = 1'b0; idle(4);
    bus.irq = 1'b1; idle(4);
    cyc(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.vec_load !== 1'b0) begin n_err++; $display("FAIL di_ib_no_take got=%b exp=0", bus.vec_load); end
    n_cmp++; if (bus.ienabled !== 1'b0) begin n_err++; $display("FAIL di_ib_ienabled got=%b exp=0", bus.ienabled); end
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL di_ib_pending got=%b exp=1", bus.pending); end
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.ienabled !== 1'b0) begin n_err++; $display("FAIL ei_di_both got=%b exp=0", bus.ienabled); end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.vec_load !== 1'b1) begin n_err++; $display("FAIL di_retake got=%b exp=1", bus.vec_load); end
    idle(1);
  endtask

  task automatic test_nested();
    bus.irq = 1'b0; idle(4);
    bus.irq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      n_cmp++; if (bus.vec_load !== 1'b0 || bus.istatus !== 1'b1) begin n_err++; $display("FAIL nest_stay i=%0d got vec_load=%b istatus=%b exp 0/1", i, bus.vec_load, bus.istatus); end
    end
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL nest_pending got=%b exp=1", bus.pending); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.ret_load !== 1'b1) begin n_err++; $display("FAIL nest_ret got=%b exp=1", bus.ret_load); end
    idle(1);
    n_cmp++; if (bus.istatus !== 1'b0 || bus.pending !== 1'b1) begin n_err++; $display("FAIL nest_idle got istatus=%b pending=%b exp 0/1", bus.istatus, bus.pending); end
    cyc(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.vec_load !== 1'b1 || bus.intRA !== 16'h5555) begin n_err++; $display("FAIL nest_retake got vec_load=%b intRA=%h exp 1/5555", bus.vec_load, bus.intRA); end
    idle(1);
  endtask

  task automatic test_reset_active();
    bus.irq = 1'b0; idle(4);
    bus.irq = 1'b1; idle(4);
    @(negedge clk);
    #2 nclr = 1'b0;
    #1;
    n_cmp++; if (bus.istatus !== 1'b0 || bus.ienabled !== 1'b0 || bus.pending !== 1'b0) begin n_err++; $display("FAIL async_clr got istatus=%b ienabled=%b pending=%b exp 000", bus.istatus, bus.ienabled, bus.pending); end
    n_cmp++; if (bus.intRA !== 16'h0000) begin n_err++; $display("FAIL async_clr_intRA got=%h exp=0000", bus.intRA); end
    @(negedge clk);
    nclr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      n_cmp++; if (bus.ret_load !== 1'b0 || bus.istatus !== 1'b0) begin n_err++; $display("FAIL post_clr i=%0d got ret_load=%b istatus=%b exp 0/0", i, bus.ret_load, bus.istatus); end
    end
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL held_irq_pending got=%b exp=1", bus.pending); end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.vec_load !== 1'b1) begin n_err++; $display("FAIL held_take got=%b exp=1", bus.vec_load); end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL held_no_reset i=%0d got=%b exp=0", i, bus.pending); end
    end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bus.irq = ~bus.irq;
      cyc(($urandom_range(0, 9) < 3), 16'($urandom), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 6) == 0));
      n_cmp++;
      if (bus.pending !== m_pend || bus.ienabled !== m_ien || bus.intRA !== m_ra ||
          bus.istatus !== (m_mode >= 2) || bus.vec_load !== (m_mode == 1) || bus.ret_load !== (m_mode == 3)) begin
        n_err++;
        $display("FAIL rand i=%0d got p=%b e=%b ra=%h is=%b vl=%b rl=%b exp p=%b e=%b ra=%h mode=%0d",
                 i, bus.pending, bus.ienabled, bus.intRA, bus.istatus, bus.vec_load, bus.ret_load,
                 m_pend, m_ien, m_ra, m_mode);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_take();
    test_return();
    test_disabled();
    test_di_same();
    test_nested();
    test_reset_active();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
